// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    // Width of one {pc, instr} entry handed to the core
    localparam int unsigned FETCH_W = 64;

    // addi x0,x0,0 used as the bubble instruction
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch control states
    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_DISCARD,
        ST_HALT
    } fetch_state_e;

    // Entry presented to the core when nothing valid is available
    function automatic logic [FETCH_W-1:0] bubble_word();
        return {32'h0000_0000, NOP_INSTR};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular FIFO of {pc, instr} entries with occupancy count.
// Flush has priority over push and pop; push and pop together are legal at any count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [FETCH_W-1:0]       i_wdata,
    output logic [FETCH_W-1:0]       o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [FETCH_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;

    // Entry storage; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues sequential word fetches (one outstanding at most), buffers
// responses in a prefetch FIFO and presents the head {pc, instr} to the core.
// Handles core stalls, redirects and halting on ecall.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 icache_req,
    output logic [31:0]          icache_addr,
    input  logic                 icache_ready,
    input  logic                 icache_valid,
    input  logic [31:0]          icache_data,
    output logic [FETCH_W-1:0]   fetch_instr_pc,
    input  logic                 stop,
    input  logic                 stop_fetch,
    input  logic                 ecall,
    input  logic                 j_accept,
    input  logic [31:0]          j_addr,
    output logic                 halted
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0]                 r_fpc;
    logic [31:0]                 r_req_pc;

    logic [FETCH_W-1:0]          w_head;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    logic                        w_pop;
    logic                        w_halt_go;
    logic                        w_redirect;
    logic                        w_outstanding;
    logic                        w_room;
    logic                        w_issue;
    logic                        w_accept;
    logic                        w_push;
    logic                        w_flush;
    logic [31:0]                 w_j_target;

    assign w_j_target    = j_addr & 32'hFFFF_FFFC;
    assign w_pop         = !w_empty && !stop && !stop_fetch && (r_state != ST_HALT);
    assign w_halt_go     = w_pop && ecall;
    assign w_redirect    = j_accept && !w_halt_go && (r_state != ST_HALT);
    assign w_outstanding = (r_state == ST_WAIT) || (r_state == ST_DISCARD);
    assign w_room        = (32'(w_count) + 32'(w_outstanding)) < FIFO_DEPTH;
    // Request is held low through reset and during the redirect/halt cycle itself
    assign w_issue       = rst_n && (r_state == ST_RUN) && w_room && !w_redirect && !w_halt_go;
    assign w_accept      = w_issue && icache_ready;
    assign w_push        = (r_state == ST_WAIT) && icache_valid && !w_redirect && !w_halt_go;
    assign w_flush       = w_redirect || w_halt_go || (r_state == ST_HALT);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata ({r_req_pc, icache_data}),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: halt beats redirect, redirect with a pending response goes to DISCARD
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN:     if (w_accept)     w_state_nxt = ST_WAIT;
            ST_WAIT:    if (icache_valid) w_state_nxt = ST_RUN;
            ST_DISCARD: if (icache_valid) w_state_nxt = ST_RUN;
            ST_HALT:    w_state_nxt = ST_HALT;
            default:    w_state_nxt = ST_RUN;
        endcase
        if (w_redirect && w_outstanding && !icache_valid) begin
            w_state_nxt = ST_DISCARD;
        end
        if (w_halt_go) begin
            w_state_nxt = ST_HALT;
        end
    end

    // Fetch PC and address of the in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc    <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_fpc <= w_j_target;
        end else if (w_accept) begin
            r_req_pc <= r_fpc;
            r_fpc    <= r_fpc + 32'd4;
        end
    end

    assign icache_req     = w_issue;
    assign icache_addr    = r_fpc;
    assign halted         = (r_state == ST_HALT);
    assign fetch_instr_pc = (w_empty || (r_state == ST_HALT)) ? bubble_word() : w_head;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: randomized ICache/core behaviour
// checked against an in-order stream model of expected fetch and consume PCs.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [63:0] BUBBLE = {32'h0000_0000, 32'h0000_0013};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic        icache_valid;
    logic [31:0] icache_data;
    logic [63:0] fetch_instr_pc;
    logic        stop;
    logic        stop_fetch;
    logic        ecall;
    logic        j_accept;
    logic [31:0] j_addr;
    logic        halted;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_ready   (icache_ready),
        .icache_valid   (icache_valid),
        .icache_data    (icache_data),
        .fetch_instr_pc (fetch_instr_pc),
        .stop           (stop),
        .stop_fetch     (stop_fetch),
        .ecall          (ecall),
        .j_accept       (j_accept),
        .j_addr         (j_addr),
        .halted         (halted)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [31:0] exp_pc;        // PC the core must see next at the head
    logic [31:0] exp_issue;     // address of the next fetch request
    bit          halted_exp;
    bit          post_redirect;
    bit          pend;          // ICache has an accepted request in flight
    logic [31:0] pend_addr;
    int unsigned pend_delay;
    int unsigned pops;
    bit          wrap_seen;
    logic [31:0] last_acc;

    // Stimulus knobs (percent probabilities, latency bound)
    int unsigned p_stop, p_stopf, p_ready, p_jmp, lat_max;
    bit          force_j;
    logic [31:0] force_addr;
    bit          want_ecall;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Instruction memory image; bit 31 set so no word can look like the bubble
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a * 32'h9E37_79B1) ^ 32'h00A5_5A00) | 32'h8000_0000;
    endfunction

    task automatic do_reset();
        rst_n        = 1'b0;
        icache_valid = 1'b0;
        icache_ready = 1'b0;
        icache_data  = '0;
        stop         = 1'b0;
        stop_fetch   = 1'b0;
        ecall        = 1'b0;
        j_accept     = 1'b0;
        j_addr       = '0;
        pend          = 1'b0;
        exp_pc        = RST_PC;
        exp_issue     = RST_PC;
        halted_exp    = 1'b0;
        post_redirect = 1'b0;
        force_j       = 1'b0;
        want_ecall    = 1'b0;
        #1;
        check_eq("rst_req", icache_req, 0);
        check_eq("rst_addr", icache_addr, RST_PC);
        check_eq("rst_head", fetch_instr_pc, BUBBLE);
        check_eq("rst_halted", halted, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, sample outputs before the rising edge, advance the model
    task automatic step();
        logic [63:0] head;
        logic [31:0] ja;
        bit hv, jmp, cons, hgo, acc, busy;
        @(negedge clk);
        icache_valid = pend && (pend_delay == 0);
        icache_data  = icache_valid ? mem_word(pend_addr) : $urandom();
        stop         = ($urandom_range(99) < p_stop);
        stop_fetch   = ($urandom_range(99) < p_stopf);
        icache_ready = ($urandom_range(99) < p_ready);
        #1;
        head = fetch_instr_pc;
        hv   = (head != BUBBLE);
        jmp  = 1'b0;
        ja   = $urandom();
        if (hv && !halted_exp) begin
            if (force_j) begin
                jmp     = 1'b1;
                ja      = force_addr;
                force_j = 1'b0;
            end else if ($urandom_range(99) < p_jmp) begin
                jmp = 1'b1;
                ja  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                               : ($urandom() & 32'hFFF);
            end
        end
        j_accept = jmp;
        j_addr   = ja;
        ecall    = want_ecall && hv;
        #1;
        if (post_redirect) check_eq("post_redirect_bubble", head, BUBBLE);
        post_redirect = 1'b0;
        check_eq("halted", halted, halted_exp);
        if (halted_exp) begin
            check_eq("halt_head", head, BUBBLE);
            check_eq("halt_req", icache_req, 0);
        end else if (hv) begin
            check_eq("head", head, {exp_pc, mem_word(exp_pc)});
        end
        cons = hv && ((!stop && !stop_fetch) || jmp);
        hgo  = hv && !stop && !stop_fetch && ecall;
        acc  = icache_req && icache_ready;
        if (jmp && !hgo) check_eq("req_on_redirect", icache_req, 0);
        if (acc) begin
            busy = pend && !icache_valid;
            check_eq("one_outstanding", busy, 0);
            check_eq("issue_addr", icache_addr, exp_issue);
            if (icache_addr == 32'h0 && last_acc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
            last_acc = icache_addr;
        end
        if (cons) begin
            pops++;
            exp_pc = exp_pc + 32'd4;
        end
        if (hgo) begin
            halted_exp = 1'b1;
        end else if (jmp) begin
            exp_pc        = ja & 32'hFFFF_FFFC;
            exp_issue     = ja & 32'hFFFF_FFFC;
            post_redirect = 1'b1;
        end
        if (icache_valid) pend = 1'b0;
        else if (pend) pend_delay--;
        if (acc) begin
            pend       = 1'b1;
            pend_addr  = icache_addr;
            pend_delay = $urandom_range(lat_max - 1, 0);
            exp_issue  = exp_issue + 32'd4;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        last_acc  = 32'h1;
        wrap_seen = 1'b0;
        p_stop = 0; p_stopf = 0; p_ready = 100; p_jmp = 0; lat_max = 1;
        #3;
        do_reset();

        // Straight-line streaming with a 1-cycle ICache
        pops = 0;
        repeat (40) step();
        check_eq("stream_progress", (pops >= 15), 1);

        // Long structural stall: FIFO fills and requests stop, then drains in order
        p_stopf = 100;
        repeat (14) step();
        check_eq("full_no_req", icache_req, 0);
        p_stopf = 0;
        repeat (20) step();

        // Randomized stalls, latencies, backpressure and redirects
        p_stop = 20; p_stopf = 20; p_ready = 70; p_jmp = 8; lat_max = 4;
        repeat (400) step();

        // Redirect near the top of memory: fetch address wraps to 0
        p_stop = 0; p_stopf = 0; p_ready = 100; p_jmp = 0; lat_max = 1;
        repeat (6) step();
        wrap_seen  = 1'b0;
        force_addr = 32'hFFFF_FFF6;
        force_j    = 1'b1;
        for (int i = 0; i < 50 && force_j; i++) step();
        check_eq("wrap_jump_taken", force_j, 0);
        repeat (20) step();
        check_eq("wrap_seen", wrap_seen, 1);

        // Halt on ecall at the head; only reset clears it
        do_reset();
        repeat (10) step();
        want_ecall = 1'b1;
        for (int i = 0; i < 50 && !halted_exp; i++) step();
        check_eq("halt_reached", halted_exp, 1);
        want_ecall = 1'b0;
        p_jmp = 10;
        repeat (20) step();
        p_jmp = 0;

        // Reset asserted while a request is outstanding
        do_reset();
        lat_max = 4;
        repeat (5) step();
        for (int i = 0; i < 50 && !pend; i++) step();
        check_eq("wait_reached", pend, 1);
        @(posedge clk);
        #2;
        do_reset();
        lat_max = 1;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
